if_prefetch_stage: RTL and testbench

- Parametrised next-generation instruction-fetch stage for the MIPS pipeline.
- Issues in-order requests to an instruction memory that can stall (grant) and has variable latency (response valid).
- Buffers returned words in a DEPTH-entry prefetch queue, presented to ID with a valid/ready handshake.
- On a taken branch, redirects the PC, flushes the queue and discards responses still in flight.

---
 rtl/mips_pkg.sv | 15 +
 rtl/if_prefetch_stage_if.sv | 35 +++
 rtl/if_prefetch_stage_sync_fifo.sv | 60 ++++++
 rtl/if_prefetch_stage.sv | 123 ++++++++++++
 tb/tb_if_prefetch_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-path definitions for the MIPS pipeline.
// Default widths, reset PC and the prefetch entry layout.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = '0;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc_plus_step;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Fetch-stage bus bundle: redirect, instruction memory, ID handshake.
// master is the fetch stage, slave is the memory/ID side.
interface if_prefetch_stage_if #(
    parameter int XLEN = mips_pkg::XLEN
);

    logic            br_taken;
    logic [XLEN-1:0] br_addr;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;

    modport master (
        input  br_taken, br_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  out_ready,
        output imem_req, imem_addr,
        output out_valid, out_pc, out_instr
    );

    modport slave (
        output br_taken, br_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output out_ready,
        input  imem_req, imem_addr,
        input  out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/if_prefetch_stage_sync_fifo.sv
// Single-clock FIFO with flush; push while full is allowed
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; flush drops all entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch with credit-limited prefetch queue and
// redirect flush that drops responses still in flight.
module if_prefetch_stage #(
    parameter int              XLEN     = mips_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(mips_pkg::RESET_PC),
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(mips_pkg::PC_STEP)
) (
    input  logic                 clk,
    input  logic                 rst,
    if_prefetch_stage_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIMIT = DEPTH[CW:0];

    logic [XLEN-1:0]   fetch_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW:0]       credit_used;
    logic              accept;
    logic              dropping;
    logic              q_push;
    logic              q_pop;
    logic [2*XLEN-1:0] q_din;
    logic [2*XLEN-1:0] q_dout;
    logic [CW-1:0]     q_count;
    logic              q_full;
    logic              q_empty;
    logic [XLEN-1:0]   af_dout;
    logic [CW-1:0]     af_count;
    logic              af_full;
    logic              af_empty;

    // Queued words plus words in flight never exceed the queue size,
    // so every response always has a slot waiting for it.
    assign credit_used   = {1'b0, q_count} + {1'b0, outstanding};
    assign bus.imem_req  = !rst && (credit_used < LIMIT) && !bus.br_taken;
    assign bus.imem_addr = fetch_pc;
    assign accept        = bus.imem_req && bus.imem_gnt;

    assign dropping = (drop_cnt != '0) || bus.br_taken;
    assign q_push   = bus.imem_rvalid && !dropping;
    assign q_pop    = !q_empty && bus.out_ready && !bus.br_taken;
    assign q_din    = {af_dout + PC_STEP, bus.imem_rdata};

    assign bus.out_valid = !q_empty;
    assign {bus.out_pc, bus.out_instr} = q_dout;

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .flush (bus.br_taken),
        .dout  (q_dout),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Stale addresses are never flushed: each dropped response
    // pops its own address, keeping the pairing intact.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (fetch_pc),
        .pop   (bus.imem_rvalid),
        .flush (1'b0),
        .dout  (af_dout),
        .count (af_count),
        .full  (af_full),
        .empty (af_empty)
    );

    // PC, in-flight count and number of responses left to discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept)
                         - CW'(bus.imem_rvalid);
            if (bus.br_taken) begin
                fetch_pc <= bus.br_addr;
                drop_cnt <= outstanding - CW'(bus.imem_rvalid);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (bus.imem_rvalid && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    // Simulation-only protocol and bookkeeping sanity checks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.imem_rvalid && outstanding == '0))
                else $error("imem_rvalid with no request outstanding");
            assert (!(bus.imem_rvalid && af_empty))
                else $error("imem_rvalid with empty address fifo");
            assert (af_count == outstanding)
                else $error("address fifo out of step with outstanding");
            assert (!(accept && af_full))
                else $error("request accepted with full address fifo");
            assert (!(q_push && q_full && !q_pop))
                else $error("prefetch queue overflow");
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed and random checks of the prefetch fetch stage against
// a stream-level model with epoch-tagged in-flight requests.
module tb_if_prefetch_stage;
    import mips_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    if_prefetch_stage_if #(.XLEN(32)) bus ();

    if_prefetch_stage #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0),
        .PC_STEP  (32'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    req_t         pend[$];
    fetch_entry_t mq[$];
    logic [31:0]  grant_log[$];
    logic [31:0]  deliv_log[$];
    logic [31:0]  model_pc;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int epoch = 0;
    int lat = 1;
    int extra_max = 0;
    int first_grant_cyc = -1;
    int first_valid_cyc = -1;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        grant_log.delete();
        deliv_log.delete();
        first_grant_cyc = -1;
        first_valid_cyc = -1;
    endtask

    // Asynchronous reset, checked before any clock edge.
    task automatic reset_dut();
        rst             = 1'b1;
        bus.br_taken    = 1'b0;
        bus.br_addr     = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.out_ready   = 1'b0;
        #1;
        chk("rst_req", bus.imem_req, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_instr", bus.out_instr, 0);
        pend.delete();
        mq.delete();
        model_pc = 32'h0;
        epoch++;
        clear_logs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    // One clock: drive, check against the model, advance the model.
    task automatic cycle(input logic br, input logic [31:0] baddr,
                         input logic ready, input logic gnt);
        logic exp_req;
        int   due;
        req_t r;
        bus.br_taken  = br;
        bus.br_addr   = baddr;
        bus.out_ready = ready;
        bus.imem_gnt  = gnt;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = word_of(pend[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
        exp_req = !br && (mq.size() + pend.size() < DEPTH);
        chk("imem_req", bus.imem_req, exp_req);
        if (exp_req) chk("imem_addr", bus.imem_addr, model_pc);
        chk("out_valid", bus.out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_pc", bus.out_pc, mq[0].pc_plus_step);
            chk("out_instr", bus.out_instr, mq[0].instr);
        end
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.imem_req && gnt) begin
            grant_log.push_back(bus.imem_addr);
            if (first_grant_cyc < 0) first_grant_cyc = cyc;
        end
        if (bus.out_valid && ready && !br) deliv_log.push_back(bus.out_pc);
        if (mq.size() != 0 && ready && !br) void'(mq.pop_front());
        if (bus.imem_rvalid) begin
            r = pend.pop_front();
            if (!br && r.epoch == epoch)
                mq.push_back('{pc_plus_step: r.addr + 32'd4,
                               instr: word_of(r.addr)});
        end
        if (exp_req && gnt) begin
            due = cyc + lat + int'($urandom_range(0, extra_max));
            if (pend.size() > 0 && due < pend[$].due) due = pend[$].due;
            pend.push_back('{addr: model_pc, due: due, epoch: epoch});
            model_pc = model_pc + 32'd4;
        end
        if (br) begin
            epoch++;
            mq.delete();
            model_pc = baddr;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] ba;
        @(posedge clk);
        #1;
        reset_dut();

        // Streaming with 1-cycle memory and ready ID
        lat = 1;
        extra_max = 0;
        repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("lat_first_valid", first_valid_cyc - first_grant_cyc, 2);
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", grant_log[i], 32'(4 * i));
            chk("seq_pc", deliv_log[i], 32'(4 * i + 4));
        end

        // Stalled ID fills the queue, then drains in order
        reset_dut();
        repeat (10) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("full_grants", grant_log.size(), 4);
        chk("full_noreq", bus.imem_req, 0);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("drain_n", deliv_log.size() >= 4, 1);
        chk("resume_n", grant_log.size() >= 5, 1);
        if (deliv_log.size() >= 4)
            for (int i = 0; i < 4; i++)
                chk("drain_pc", deliv_log[i], 32'(4 * i + 4));
        if (grant_log.size() >= 5)
            chk("resume_addr", grant_log[4], 32'h10);

        // Toggling grant and 3-cycle latency
        reset_dut();
        lat = 3;
        repeat (60) cycle(1'b0, 32'h0, 1'($urandom_range(0, 1)), cyc[0]);
        for (int i = 0; i < grant_log.size(); i++)
            chk("tog_addr", grant_log[i], 32'(4 * i));
        for (int i = 0; i < deliv_log.size(); i++)
            chk("tog_pc", deliv_log[i], 32'(4 * i + 4));

        // Redirect with queued words and two requests in flight
        reset_dut();
        lat = 2;
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h100, 1'b1, 1'b1);
        chk("redir_flush", bus.out_valid, 0);
        clear_logs();
        repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("redir_ndeliv", deliv_log.size() >= 1, 1);
        if (deliv_log.size() >= 1) chk("redir_first", deliv_log[0], 32'h104);
        chk("redir_addr", grant_log[0], 32'h100);

        // Back-to-back redirects: only the later target survives
        reset_dut();
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h200, 1'b1, 1'b1);
        clear_logs();
        cycle(1'b1, 32'h300, 1'b1, 1'b1);
        repeat (15) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("br2_ndeliv", deliv_log.size() >= 4, 1);
        for (int i = 0; i < deliv_log.size(); i++)
            chk("br2_pc", deliv_log[i], 32'h304 + 32'(4 * i));

        // PC wrap at the top of the address space
        reset_dut();
        lat = 1;
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        clear_logs();
        repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_a0", grant_log[0], 32'hFFFF_FFFC);
        chk("wrap_a1", grant_log[1], 32'h0);
        chk("wrap_pc0", deliv_log[0], 32'h0);
        chk("wrap_pc1", deliv_log[1], 32'h4);

        // Random traffic with redirects and a mid-run reset
        reset_dut();
        extra_max = 2;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = int'($urandom_range(1, 3));
            if (i == 200) reset_dut();
            if ($urandom_range(0, 19) == 0) begin
                ba = ($urandom_range(0, 2) == 0) ? model_pc
                                                 : ($urandom & 32'hFFFF_FFFC);
                cycle(1'b1, ba, 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                cycle(1'b0, 32'h0, 1'($urandom_range(0, 9) < 7),
                      1'($urandom_range(0, 3) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
